// File: rtl/bit_mem_pkg.sv
// Shared constants and FSM encoding for the 16x1 pattern bit memory write path.
package bit_mem_pkg;

  localparam int BIT_MEM_DEPTH        = 16;
  localparam int BIT_MEM_ADDR_W       = 4;
  localparam int DEBOUNCE_100MHZ_10MS = 1000000;
  localparam int DEBOUNCE_CNT_W       = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FULL  = 2'd2
  } writer_state_e;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer followed by a stability counter; level only moves after
// the synchronized input has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
module button_debouncer
  import bit_mem_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_100MHZ_10MS,
  parameter int DB_CNT_W        = DEBOUNCE_CNT_W
) (
  input  logic clock_100Mhz,
  input  logic reset,
  input  logic raw,
  output logic level
);

  logic                sync1_q;
  logic                sync2_q;
  logic [DB_CNT_W-1:0] cnt_q;
  logic [DB_CNT_W-1:0] cnt_d;
  logic                level_q;
  logic                level_d;

  // Any agreement between input and level restarts the stability window.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == DB_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/bit_stream_writer.sv
// Write side of the pattern bit memory: each debounced button press stores the
// synchronized slide-switch bit at the next BRAM address until the memory is full.
module bit_stream_writer
  import bit_mem_pkg::*;
#(
  parameter int ADDR_W          = BIT_MEM_ADDR_W,
  parameter int DEPTH           = BIT_MEM_DEPTH,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_100MHZ_10MS,
  parameter int DB_CNT_W        = DEBOUNCE_CNT_W
) (
  input  logic              clock_100Mhz,
  input  logic              reset,
  input  logic              bit_in,
  input  logic              btn_write,
  input  logic              clear,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic              dina,
  output logic [ADDR_W:0]   write_count,
  output logic              full,
  output logic              overflow
);

  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W + 1)'(DEPTH);

  logic          bit_sync1_q;
  logic          bit_sync2_q;
  logic          btn_level;
  logic          btn_level_q;
  logic          press;
  writer_state_e state_q;
  writer_state_e state_d;
  logic [ADDR_W:0] count_q;
  logic [ADDR_W:0] count_d;
  logic          overflow_q;
  logic          overflow_d;
  logic          dina_q;
  logic          dina_d;

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .DB_CNT_W        (DB_CNT_W)
  ) u_btn_debouncer (
    .clock_100Mhz (clock_100Mhz),
    .reset        (reset),
    .raw          (btn_write),
    .level        (btn_level)
  );

  assign press = btn_level & ~btn_level_q;
  assign full  = (count_q == CNT_FULL);

  // clear outranks every transition, so a press or WRITE alongside it is dropped.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    dina_d     = dina_q;
    if (clear) begin
      state_d    = IDLE;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (press && !full) begin
            state_d = WRITE;
            dina_d  = bit_sync2_q;
          end
        end
        WRITE: begin
          count_d = count_q + 1'b1;
          state_d = (count_d == CNT_FULL) ? FULL : IDLE;
        end
        FULL: begin
          if (press) begin
            overflow_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      bit_sync1_q <= 1'b0;
      bit_sync2_q <= 1'b0;
      btn_level_q <= 1'b0;
      state_q     <= IDLE;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      dina_q      <= 1'b0;
    end else begin
      bit_sync1_q <= bit_in;
      bit_sync2_q <= bit_sync1_q;
      btn_level_q <= btn_level;
      state_q     <= state_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      dina_q      <= dina_d;
    end
  end

  assign wea         = (state_q == WRITE) && !clear;
  assign addra       = count_q[ADDR_W-1:0];
  assign dina        = dina_q;
  assign write_count = count_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_bit_stream_writer.sv
// Self-checking bench for bit_stream_writer with a short debounce window and a
// sample-history reference model compared against the DUT every cycle.
module tb_bit_stream_writer;

  localparam int DEB = 4;

  logic       clock_100Mhz = 1'b0;
  logic       reset;
  logic       bit_in;
  logic       btn_write;
  logic       clear;
  logic       wea;
  logic [3:0] addra;
  logic       dina;
  logic [4:0] write_count;
  logic       full;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int cycleCnt = 0;
  int pulses = 0;
  int logAddr[64];
  int logDin[64];
  int logCycle[64];

  // Reference model state
  bit   btnQ[$];
  bit   bitQ[$];
  bit   syncBtn;
  bit   syncBit;
  bit   pressNow;
  bit   mLevel;
  bit   mLevelPrev;
  int   mRun;
  bit   mWriting;
  logic [4:0] mCount;
  bit   mOverflow;
  bit   mDina;
  logic [12:0] expVec;
  logic [12:0] gotVec;

  bit_stream_writer #(
    .ADDR_W          (4),
    .DEPTH           (16),
    .DEBOUNCE_CYCLES (DEB),
    .DB_CNT_W        (3)
  ) dut (
    .clock_100Mhz (clock_100Mhz),
    .reset        (reset),
    .bit_in       (bit_in),
    .btn_write    (btn_write),
    .clear        (clear),
    .wea          (wea),
    .addra        (addra),
    .dina         (dina),
    .write_count  (write_count),
    .full         (full),
    .overflow     (overflow)
  );

  always #5 clock_100Mhz = ~clock_100Mhz;

  // Synchronized inputs seen at an edge are the raw samples from two edges earlier;
  // the level flips once DEB consecutive synced samples disagree with it.
  always @(posedge clock_100Mhz) begin
    if (reset) begin
      btnQ = '{1'b0, 1'b0};
      bitQ = '{1'b0, 1'b0};
      mLevel = 0; mLevelPrev = 0; mRun = 0;
      mWriting = 0; mCount = '0; mOverflow = 0; mDina = 0;
    end else begin
      syncBtn = btnQ.pop_front();
      btnQ.push_back(btn_write);
      syncBit = bitQ.pop_front();
      bitQ.push_back(bit_in);
      pressNow = mLevel && !mLevelPrev;
      mLevelPrev = mLevel;
      if (syncBtn != mLevel) begin
        mRun++;
        if (mRun == DEB) begin
          mLevel = syncBtn;
          mRun = 0;
        end
      end else begin
        mRun = 0;
      end
      if (clear) begin
        mWriting = 0; mCount = '0; mOverflow = 0;
      end else if (mWriting) begin
        mWriting = 0;
        mCount = mCount + 5'd1;
      end else if (pressNow) begin
        if (mCount == 5'd16) mOverflow = 1;
        else begin
          mWriting = 1;
          mDina = syncBit;
        end
      end
    end
  end

  always @(posedge clock_100Mhz) begin
    #1;
    cycleCnt++;
    expVec = {mWriting && !clear, mCount[3:0], mDina, mCount, mCount == 5'd16, mOverflow};
    gotVec = {wea, addra, dina, write_count, full, overflow};
    checks++;
    if (gotVec !== expVec) begin
      errors++;
      $display("[TB] FAIL cycle %0d outputs {wea,addra,dina,count,full,ovf}: got %b expected %b",
               cycleCnt, gotVec, expVec);
    end
    if (wea === 1'b1 && pulses < 64) begin
      logAddr[pulses]  = int'(addra);
      logDin[pulses]   = int'(dina);
      logCycle[pulses] = cycleCnt;
      pulses++;
    end
  end

  task automatic applyStimulus(input logic rst, input logic btn, input logic bv,
                               input logic clr, input int n);
    reset     = rst;
    btn_write = btn;
    bit_in    = bv;
    clear     = clr;
    repeat (n) @(negedge clock_100Mhz);
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  initial begin
    int base;
    int start;
    bit b;

    applyStimulus(1, 0, 0, 0, 3);
    $display("[TB] reset state");
    checkOutput("t1 wea", int'(wea), 0);
    checkOutput("t1 addra", int'(addra), 0);
    checkOutput("t1 dina", int'(dina), 0);
    checkOutput("t1 write_count", int'(write_count), 0);
    checkOutput("t1 full", int'(full), 0);
    checkOutput("t1 overflow", int'(overflow), 0);

    $display("[TB] single held press");
    base = pulses;
    start = cycleCnt;
    applyStimulus(0, 1, 1, 0, 12);
    applyStimulus(0, 0, 1, 0, 12);
    checkOutput("t2 pulse count", pulses - base, 1);
    checkOutput("t2 addra", logAddr[base], 0);
    checkOutput("t2 dina", logDin[base], 1);
    checkOutput("t2 press-to-wea latency", logCycle[base] - start, 7);
    checkOutput("t2 write_count", int'(write_count), 1);

    $display("[TB] bounce rejection");
    base = pulses;
    for (int r = 0; r < 2; r++) begin
      applyStimulus(0, 1, 0, 0, 2);
      applyStimulus(0, 0, 0, 0, 2);
    end
    applyStimulus(0, 0, 0, 0, 10);
    checkOutput("t3 pulse count", pulses - base, 0);
    checkOutput("t3 write_count", int'(write_count), 1);

    $display("[TB] fill to full");
    applyStimulus(0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 2);
    checkOutput("t4 count after clear", int'(write_count), 0);
    base = pulses;
    for (int i = 0; i < 16; i++) begin
      b = (i % 2 == 0);
      applyStimulus(0, 1, b, 0, 8);
      applyStimulus(0, 0, b, 0, 8);
    end
    checkOutput("t4 pulse count", pulses - base, 16);
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("t4 addra[%0d]", i), logAddr[base + i], i);
      checkOutput($sformatf("t4 dina[%0d]", i), logDin[base + i], (i % 2 == 0) ? 1 : 0);
    end
    checkOutput("t4 full", int'(full), 1);
    checkOutput("t4 write_count", int'(write_count), 16);
    checkOutput("t4 overflow before extra press", int'(overflow), 0);
    checkOutput("t4 addra while full", int'(addra), 0);
    base = pulses;
    applyStimulus(0, 1, 1, 0, 8);
    applyStimulus(0, 0, 1, 0, 8);
    checkOutput("t4 extra press pulses", pulses - base, 0);
    checkOutput("t4 overflow", int'(overflow), 1);
    checkOutput("t4 write_count held", int'(write_count), 16);

    $display("[TB] clear behaviour");
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("t5 write_count", int'(write_count), 0);
    checkOutput("t5 full", int'(full), 0);
    checkOutput("t5 overflow", int'(overflow), 0);
    applyStimulus(0, 0, 0, 0, 2);
    base = pulses;
    applyStimulus(0, 1, 1, 0, 6);
    applyStimulus(0, 1, 1, 1, 2);
    applyStimulus(0, 1, 1, 0, 4);
    applyStimulus(0, 0, 1, 0, 10);
    checkOutput("t5 clear vs write pulses", pulses - base, 0);
    checkOutput("t5 clear vs write count", int'(write_count), 0);

    $display("[TB] reset during held press");
    applyStimulus(0, 0, 1, 0, 10);
    base = pulses;
    applyStimulus(0, 1, 1, 0, 2);
    applyStimulus(1, 1, 1, 0, 2);
    applyStimulus(0, 1, 1, 0, 4);
    checkOutput("t6 early pulses", pulses - base, 0);
    checkOutput("t6 early count", int'(write_count), 0);
    applyStimulus(0, 1, 1, 0, 10);
    checkOutput("t6 pulses", pulses - base, 1);
    checkOutput("t6 addra", logAddr[base], 0);
    checkOutput("t6 dina", logDin[base], 1);
    checkOutput("t6 write_count", int'(write_count), 1);
    applyStimulus(0, 0, 1, 0, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
